// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - memory-stage front end that drives dmemory and splits misaligned accesses into bytes
module dmem_access_unit #(
    parameter logic MISALIGN_SPLIT = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_split,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [1:0]  mem_access_size,
    output logic        mem_load_un,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SPLIT, S_RESP} state_t;

    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_BAD  = 2'd3;

    state_t      state_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  k_q;
    logic [31:0] asm_q;
    logic [31:0] asm_d;

    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_split_q;
    logic        resp_error_q;
    logic [31:0] mem_addr_q;
    logic        mem_rw_q;
    logic [1:0]  mem_size_q;
    logic        mem_un_q;
    logic [31:0] mem_din_q;

    logic        misaligned_req;
    logic [1:0]  k_next;
    logic [1:0]  last_k;
    logic [7:0]  next_wbyte;
    logic [31:0] split_result;

    // Request classification and split-sequence helpers
    always_comb begin
        misaligned_req = ((req_size == SZ_HALF) && req_addr[0]) ||
                         ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        k_next         = k_q + 2'd1;
        last_k         = (size_q == SZ_WORD) ? 2'd3 : 2'd1;
        next_wbyte     = wdata_q[{k_next, 3'b000} +: 8];
        asm_d          = asm_q;
        asm_d[{k_q, 3'b000} +: 8] = mem_data_out[7:0];
        split_result   = (size_q == SZ_WORD) ? asm_d
                       : {{16{asm_d[15] & ~uns_q}}, asm_d[15:0]};
    end

    // Single FSM: latches the request, sequences memory accesses and registers every output
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            k_q          <= 2'd0;
            asm_q        <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_split_q <= 1'b0;
            resp_error_q <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_rw_q     <= 1'b0;
            mem_size_q   <= 2'd0;
            mem_un_q     <= 1'b0;
            mem_din_q    <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        k_q     <= 2'd0;
                        asm_q   <= 32'd0;
                        if ((req_size == SZ_BAD) || (misaligned_req && !MISALIGN_SPLIT)) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            resp_rdata_q <= 32'd0;
                            resp_split_q <= 1'b0;
                        end else if (misaligned_req) begin
                            state_q    <= S_SPLIT;
                            mem_addr_q <= req_addr;
                            mem_rw_q   <= req_write;
                            mem_size_q <= 2'd0;
                            mem_un_q   <= 1'b1;
                            mem_din_q  <= {24'd0, req_wdata[7:0]};
                        end else begin
                            state_q    <= S_ACCESS;
                            mem_addr_q <= req_addr;
                            mem_rw_q   <= req_write;
                            mem_size_q <= req_size;
                            mem_un_q   <= req_unsigned;
                            mem_din_q  <= req_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= write_q ? 32'd0 : mem_data_out;
                    resp_split_q <= 1'b0;
                    resp_error_q <= 1'b0;
                    mem_addr_q   <= 32'd0;
                    mem_rw_q     <= 1'b0;
                    mem_size_q   <= 2'd0;
                    mem_un_q     <= 1'b0;
                    mem_din_q    <= 32'd0;
                end
                S_SPLIT: begin
                    if (!write_q) begin
                        asm_q <= asm_d;
                    end
                    if (k_q == last_k) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= write_q ? 32'd0 : split_result;
                        resp_split_q <= 1'b1;
                        resp_error_q <= 1'b0;
                        mem_addr_q   <= 32'd0;
                        mem_rw_q     <= 1'b0;
                        mem_size_q   <= 2'd0;
                        mem_un_q     <= 1'b0;
                        mem_din_q    <= 32'd0;
                    end else begin
                        k_q        <= k_next;
                        mem_addr_q <= addr_q + {30'd0, k_next};
                        mem_din_q  <= {24'd0, next_wbyte};
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 32'd0;
                    resp_split_q <= 1'b0;
                    resp_error_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready       = (state_q == S_IDLE);
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_split      = resp_split_q;
    assign resp_error      = resp_error_q;
    assign mem_address     = mem_addr_q;
    // Reset must stop the byte being written at the aborting edge, so the write strobe is masked by it
    assign mem_read_write  = mem_rw_q & ~reset;
    assign mem_access_size = mem_size_q;
    assign mem_load_un     = mem_un_q;
    assign mem_data_in     = mem_din_q;

endmodule
